reloc_ram: RTL and testbench

//   Parametrised, single-clock data RAM with per-process base relocation and

---
 rtl/reloc_ram.sv | 134 +++++++++++++
 tb/tb_reloc_ram.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reloc_ram.sv
// Single-clock data RAM with per-process base relocation and self-clear after reset.
// Define RELOC_RAM_BOUNDS_CHECK_EN to enable logical-address limit protection and the sticky fault.
module reloc_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 3179
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mW,
    input  logic [ADDR_W-1:0] ProcessOffset,
    input  logic [ADDR_W-1:0] ProcessLimit,
    input  logic              OffsetChange,
    output logic [DATA_W-1:0] DataOut,
    output logic [ADDR_W-1:0] inRAMOffset,
    output logic              busy,
    output logic              fault
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] pa_c;
    logic              mapped_c;
    logic              legal_c;
    logic              clr_last_c;
    logic              clr_we_c;
    logic              rd_en_c;
    logic              ram_we_c;
    logic              ld_ctx_c;

    // Relocated address wraps modulo 2**ADDR_W; anything at or above DEPTH is unmapped.
    assign pa_c       = addr + offset_q;
    assign mapped_c   = (ADDR_W+1)'(pa_c) < (ADDR_W+1)'(DEPTH);
    assign clr_last_c = (clr_cnt_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_CLEAR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && clr_last_c) state_d = ST_READY;
    end

    always_comb begin
        clr_we_c = 1'b0;
        rd_en_c  = 1'b0;
        ram_we_c = 1'b0;
        ld_ctx_c = 1'b0;
        case (state_q)
            ST_CLEAR: clr_we_c = 1'b1;
            ST_READY: begin
                rd_en_c  = 1'b1;
                ram_we_c = mW & mapped_c & legal_c;
                ld_ctx_c = OffsetChange;
            end
            default: ;
        endcase
    end

    always_comb begin
        clr_cnt_d = clr_we_c ? clr_cnt_q + ADDR_W'(1) : clr_cnt_q;
        offset_d  = ld_ctx_c ? ProcessOffset : offset_q;
        dout_d    = (rd_en_c && mapped_c && legal_c) ? mem[pa_c] : '0;
    end

    // Storage has no reset; the CLEAR walk zeroes it instead.
    always_ff @(posedge clk) begin
        if (clr_we_c)      mem[clr_cnt_q] <= '0;
        else if (ram_we_c) mem[pa_c]      <= data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
            offset_q  <= '0;
            dout_q    <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
            offset_q  <= offset_d;
            dout_q    <= dout_d;
        end
    end

`ifdef RELOC_RAM_BOUNDS_CHECK_EN
    logic [ADDR_W-1:0] limit_q, limit_d;
    logic              fault_q, fault_d;

    // Limit is checked on the logical address, against the limit in force before any reload.
    assign legal_c = (addr <= limit_q);

    always_comb begin
        limit_d = ld_ctx_c ? ProcessLimit : limit_q;
        fault_d = fault_q;
        if (ld_ctx_c)                 fault_d = 1'b0;
        else if (rd_en_c && !legal_c) fault_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_q <= '1;
            fault_q <= 1'b0;
        end else begin
            limit_q <= limit_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    logic unused_limit;

    assign legal_c      = 1'b1;
    assign unused_limit = ^ProcessLimit;
    assign fault        = 1'b0;
`endif

    assign DataOut     = dout_q;
    assign inRAMOffset = offset_q;
    assign busy        = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_reloc_ram.sv
// Randomized self-checking bench for reloc_ram against an array-based reference model.
module tb_reloc_ram;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 3179;
`ifdef RELOC_RAM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic [ADDR_W-1:0] addr = '0;
    logic              mW = 1'b0;
    logic [ADDR_W-1:0] ProcessOffset = '0;
    logic [ADDR_W-1:0] ProcessLimit = '1;
    logic              OffsetChange = 1'b0;
    logic [DATA_W-1:0] DataOut;
    logic [ADDR_W-1:0] inRAMOffset;
    logic              busy;
    logic              fault;

    reloc_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .mW(mW),
        .ProcessOffset(ProcessOffset), .ProcessLimit(ProcessLimit),
        .OffsetChange(OffsetChange), .DataOut(DataOut),
        .inRAMOffset(inRAMOffset), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int unsigned       m_clr;
    logic [ADDR_W-1:0] m_off;
    logic [ADDR_W-1:0] m_lim;
    logic              m_fault;
    logic [DATA_W-1:0] m_out;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("dout",  DataOut, m_out);
        check_eq("base",  32'(inRAMOffset), 32'(m_off));
        check_eq("busy",  32'(busy), (m_clr < DEPTH) ? 32'd1 : 32'd0);
        check_eq("fault", 32'(fault), 32'(m_fault));
    endtask

    task automatic model_reset();
        m_clr   = 0;
        m_off   = '0;
        m_lim   = '1;
        m_fault = 1'b0;
        m_out   = '0;
        // The post-reset clear always completes before any access can land.
        foreach (ref_mem[i]) ref_mem[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_dout",  DataOut, 32'd0);
        check_eq("rst_busy",  32'(busy), 32'd1);
        check_eq("rst_base",  32'(inRAMOffset), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, apply the access rules to the model, compare after the edge.
    task automatic step(input logic [ADDR_W-1:0] a, input logic w, input logic [DATA_W-1:0] d,
                        input logic oc, input logic [ADDR_W-1:0] po, input logic [ADDR_W-1:0] pl);
        int  pa;
        bit  legal;
        bit  mapped;
        addr = a; mW = w; data = d; OffsetChange = oc; ProcessOffset = po; ProcessLimit = pl;
        @(posedge clk);
        if (m_clr < DEPTH) begin
            m_clr++;
            m_out = '0;
        end else begin
            legal  = !BOUNDS || (int'(a) <= int'(m_lim));
            pa     = (int'(a) + int'(m_off)) % (1 << ADDR_W);
            mapped = pa < int'(DEPTH);
            m_out  = (legal && mapped) ? ref_mem[pa] : '0;
            if (w && legal && mapped) ref_mem[pa] = d;
            if (BOUNDS && !legal) m_fault = 1'b1;
            if (oc) begin
                m_off   = po;
                m_lim   = pl;
                m_fault = 1'b0;
            end
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic rand_step();
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] po;
        logic [ADDR_W-1:0] pl;
        a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 63));
        case ($urandom_range(0, 3))
            0:       po = 12'h000;
            1:       po = 12'h100;
            2:       po = 12'hFF0;
            default: po = ADDR_W'($urandom);
        endcase
        pl = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : 12'hFFF;
        step(a, 1'($urandom), DATA_W'($urandom), ($urandom_range(0, 15) == 0), po, pl);
    endtask

    initial begin
        do_reset();

        // Clear phase with random traffic that must be ignored
        for (int i = 0; i < int'(DEPTH); i++) rand_step();
        check_eq("clear_done", 32'(busy), 32'd0);
        check_eq("clear_base", 32'(inRAMOffset), 32'd0);

        step(12'hBAD, 1'b0, '0, 1'b0, '0, '1);
        check_eq("cleared_read", DataOut, 32'd0);

        step(12'h005, 1'b1, 32'hDEADBEEF, 1'b0, '0, '1);
        step(12'h005, 1'b0, '0, 1'b0, '0, '1);
        check_eq("rd_deadbeef", DataOut, 32'hDEADBEEF);

        step(12'h000, 1'b0, '0, 1'b1, 12'h100, '1);
        check_eq("base_100", 32'(inRAMOffset), 32'h100);
        step(12'h005, 1'b1, 32'h1234, 1'b0, '0, '1);
        step(12'h000, 1'b0, '0, 1'b1, 12'h000, '1);
        step(12'h105, 1'b0, '0, 1'b0, '0, '1);
        check_eq("reloc_1234", DataOut, 32'h1234);

        step(12'h009, 1'b1, 32'hA, 1'b0, '0, '1);
        step(12'h009, 1'b1, 32'hB, 1'b0, '0, '1);
        check_eq("read_first_old", DataOut, 32'hA);
        step(12'h009, 1'b0, '0, 1'b0, '0, '1);
        check_eq("read_first_new", DataOut, 32'hB);

        step(12'h000, 1'b0, '0, 1'b1, 12'hFF0, '1);
        step(12'h020, 1'b1, 32'hC0FFEE, 1'b0, '0, '1);
        step(12'h000, 1'b0, '0, 1'b1, 12'h000, '1);
        step(12'h010, 1'b0, '0, 1'b0, '0, '1);
        check_eq("wrap_pa", DataOut, 32'hC0FFEE);

        step(12'hC80, 1'b1, 32'h5555, 1'b0, '0, '1);
        step(12'hC80, 1'b0, '0, 1'b0, '0, '1);
        check_eq("unmapped_rd", DataOut, 32'd0);

`ifdef RELOC_RAM_BOUNDS_CHECK_EN
        step(12'h000, 1'b0, '0, 1'b1, 12'h000, 12'h00F);
        step(12'h010, 1'b1, 32'h7777, 1'b0, '0, '1);
        check_eq("oob_dout", DataOut, 32'd0);
        check_eq("oob_fault", 32'(fault), 32'd1);
        step(12'h00F, 1'b0, '0, 1'b0, '0, '1);
        check_eq("fault_sticky", 32'(fault), 32'd1);
        step(12'h000, 1'b0, '0, 1'b1, 12'h000, 12'hFFF);
        check_eq("fault_cleared", 32'(fault), 32'd0);
        step(12'h010, 1'b0, '0, 1'b0, '0, '1);
        check_eq("oob_no_write", DataOut, 32'hC0FFEE);
        step(12'h000, 1'b0, '0, 1'b1, 12'h000, 12'h00F);
        step(12'h020, 1'b0, '0, 1'b1, 12'h000, 12'h00F);
        check_eq("clear_wins", 32'(fault), 32'd0);
        step(12'h020, 1'b0, '0, 1'b0, '0, '1);
        check_eq("fault_again", 32'(fault), 32'd1);
        step(12'h000, 1'b0, '0, 1'b1, 12'h000, 12'hFFF);
`endif

        for (int i = 0; i < 2000; i++) rand_step();

        // Reset in the middle of a clear must restart it from word 0
        do_reset();
        for (int i = 0; i < 100; i++) rand_step();
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) rand_step();
        check_eq("reclear_done", 32'(busy), 32'd0);
        step(12'h005, 1'b0, '0, 1'b0, '0, '1);
        check_eq("reclear_zero", DataOut, 32'd0);
        for (int i = 0; i < 500; i++) rand_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
